// File: rtl/iterative_shift_unit_if.sv
// Request/response bundle between the EX-stage issuer and the iterative shifter.
interface iterative_shift_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] data_in;
    logic [31:0]       shamt_in;
    logic [DATA_W-1:0] result;
    logic              busy;
    logic              done;

    modport master (
        output start, op, data_in, shamt_in,
        input  result, busy, done
    );

    modport slave (
        input  start, op, data_in, shamt_in,
        output result, busy, done
    );
endinterface

// File: rtl/iterative_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROTR shifter with start/busy/done handshake.
// Optional macro SHIFT_FAST_EN: shift up to 4 bits per SHIFT cycle instead of 1.
module iterative_shift_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input logic                  clk,
    input logic                  reset,
    iterative_shift_unit_if.slave bus
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, next_state;
    logic [DATA_W-1:0]   work, work_next, result_q;
    logic [SHAMT_W-1:0]  count, count_next, step, req_n;
    logic [1:0]          op_q;
    logic                accept;

    function automatic logic [DATA_W-1:0] shift_by(
        input logic [DATA_W-1:0]  v,
        input logic [1:0]         kind,
        input logic [SHAMT_W-1:0] k
    );
        logic [DATA_W-1:0] r;
        case (kind)
            OP_SLL:  r = v << k;
            OP_SRL:  r = v >> k;
            OP_SRA:  r = $signed(v) >>> k;
            default: r = (v >> k) | (v << (DATA_W - int'(k)));
        endcase
        return r;
    endfunction

    // Only the low shamt bits form the count; the extender's upper bits are don't-care.
    assign req_n  = bus.shamt_in[SHAMT_W-1:0];
    assign accept = bus.start && (state == IDLE || state == DONE);

    always_comb begin
`ifdef SHIFT_FAST_EN
        step = (count > SHAMT_W'(4)) ? SHAMT_W'(4) : count;
`else
        step = SHAMT_W'(1);
`endif
    end

    always_comb begin
        work_next  = work;
        count_next = count;
        if (accept) begin
            work_next  = bus.data_in;
            count_next = req_n;
        end else if (state == SHIFT) begin
            work_next  = shift_by(work, op_q, step);
            count_next = count - step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    next_state = (req_n == '0) ? DONE : SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            SHIFT: begin
                if (count <= step) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Result is loaded only on the edge that enters DONE, so partial shifts never leak out.
    always_ff @(posedge clk) begin
        if (reset) begin
            work     <= '0;
            count    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            work  <= work_next;
            count <= count_next;
            if (accept) begin
                op_q <= bus.op;
            end
            if (next_state == DONE) begin
                result_q <= work_next;
            end
        end
    end

    always_comb begin
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.result = result_q;
        case (state)
            SHIFT:   bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed self-checking bench for iterative_shift_unit (latency follows SHIFT_FAST_EN).
module tb_iterative_shift_unit;
    localparam logic [1:0] SLL  = 2'b00;
    localparam logic [1:0] SRL  = 2'b01;
    localparam logic [1:0] SRA  = 2'b10;
    localparam logic [1:0] ROTR = 2'b11;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    iterative_shift_unit_if #(.DATA_W(32)) bus ();

    iterative_shift_unit #(
        .DATA_W(32),
        .SHAMT_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input int n);
`ifdef SHIFT_FAST_EN
        return (n + 3) / 4;
`else
        return n;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Hold start for one capture edge, then scramble the inputs to show they are latched.
    task automatic issue(input logic [1:0] op, input logic [31:0] data, input logic [31:0] shamt);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.data_in  = data;
        bus.shamt_in = shamt;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.op       = ~op;
        bus.data_in  = ~data;
        bus.shamt_in = 32'h0000_001F;
    endtask

    task automatic waitDone(output int cycles, output int busy_cycles);
        logic [31:0] held;
        int partial;
        bit seen;
        held        = bus.result;
        partial     = 0;
        seen        = 1'b0;
        cycles      = 0;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
            if (bus.result !== held) partial++;
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        checkOutput("no_partial", 32'(partial), 32'd0);
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] data,
                                 input logic [31:0] shamt, input logic [31:0] exp_result);
        int cyc;
        int bcyc;
        int n;
        n = int'(shamt[4:0]);
        issue(op, data, shamt);
        waitDone(cyc, bcyc);
        checkOutput({tag, "_result"}, bus.result, exp_result);
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(exp_lat(n) + 1));
        checkOutput({tag, "_busy"}, 32'(bcyc), 32'(exp_lat(n)));
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_hold"}, bus.result, exp_result);
    endtask

    initial begin
        int dones;
        int cyc;
        int bcyc;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.op       = SLL;
        bus.data_in  = '0;
        bus.shamt_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_result", bus.result, 32'h0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);

        applyStimulus("sll31", SLL, 32'h0000_0001, 32'd31, 32'h8000_0000);
        applyStimulus("sra4", SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        applyStimulus("srl4", SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
        applyStimulus("rotr8", ROTR, 32'h1234_5678, 32'hFFFF_FFE8, 32'h7812_3456);
        applyStimulus("zero", SLL, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
        applyStimulus("upper", SLL, 32'h0000_0011, 32'hFFFF_FFE3, 32'h0000_0088);
        applyStimulus("rotr1", ROTR, 32'h0000_0001, 32'd1, 32'h8000_0000);

        // Start while busy must be ignored.
        issue(SLL, 32'h0000_0003, 32'd5);
        @(negedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = SRL;
        bus.data_in  = 32'hFFFF_FFFF;
        bus.shamt_in = 32'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checkOutput("ignore_dones", 32'(dones), 32'd1);
        checkOutput("ignore_result", bus.result, 32'h0000_0060);
        checkOutput("ignore_busy", 32'(bus.busy), 32'd0);

        // Back-to-back request accepted in the DONE cycle.
        issue(SLL, 32'h0000_0001, 32'd2);
        waitDone(cyc, bcyc);
        checkOutput("b2b_first", bus.result, 32'h0000_0004);
        bus.start    = 1'b1;
        bus.op       = SRL;
        bus.data_in  = 32'h0000_0100;
        bus.shamt_in = 32'd8;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(cyc, bcyc);
        checkOutput("b2b_result", bus.result, 32'h0000_0001);
        checkOutput("b2b_latency", 32'(cyc), 32'(exp_lat(8) + 1));

        // Reset sampled at E0+3 of an N=10 operation.
        issue(SLL, 32'h0000_0001, 32'd10);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_result", bus.result, 32'h0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checkOutput("abort_no_done", 32'(dones), 32'd0);
        applyStimulus("after_abort", SRL, 32'h0000_00F0, 32'd4, 32'h0000_000F);

        // Reset and start together: reset wins.
        @(negedge clk);
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.op       = SLL;
        bus.data_in  = 32'h0000_0005;
        bus.shamt_in = 32'd3;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("rs_busy", 32'(bus.busy), 32'd0);
        checkOutput("rs_result", bus.result, 32'h0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checkOutput("rs_no_done", 32'(dones), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
